// File: rtl/mc97_pkg.sv
// Shared constants for the MC97 transmit path: default widths and flow-control FSM state codes.
package mc97_pkg;

  localparam int MC97_DW    = 16;
  localparam int MC97_LVL_W = 9;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PREFILL = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  localparam int URUN_CNT_W = 16;

endpackage

// File: rtl/mc97_tx_flow_ctl.sv
// MC97 transmit flow control: prefills the sample FIFO, feeds codec slot requests, handles underrun and flush.
// Optional underrun counter output stat_urun_cnt is built when MC97_TX_FLOW_STATS_EN is defined.
module mc97_tx_flow_ctl
  import mc97_pkg::*;
#(
  parameter int LVL_W = MC97_LVL_W,
  parameter int DW    = MC97_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_ena,
  input  logic [LVL_W-1:0] cfg_start_thr,
  input  logic [LVL_W-1:0] cfg_low_thr,
  input  logic             cfg_flush_req,
  input  logic             stat_clr,
  input  logic [DW-1:0]    fifo_rd_data,
  input  logic             fifo_rd_empty,
  input  logic [LVL_W-1:0] fifo_lvl,
  output logic             fifo_rd_ena,
  output logic             fifo_flush,
  input  logic             slot_req,
  output logic [DW-1:0]    slot_data,
  output logic             slot_valid,
  output logic [1:0]       stat_state,
  output logic             stat_underrun,
  output logic             stat_low
`ifdef MC97_TX_FLOW_STATS_EN
  ,
  output logic [URUN_CNT_W-1:0] stat_urun_cnt
`endif
);

  logic [1:0] state_p0;
  logic [1:0] state_nxt;
  logic       run_p0;
  logic       pop_p0;
  logic       urun_p0;
  logic       low_p0;

  // Outputs that reach the FIFO are gated by rst so a reset cycle issues no pop or flush.
  assign run_p0  = (state_p0 == ST_RUN) && !rst;
  assign pop_p0  = run_p0 && slot_req && !cfg_flush_req && !fifo_rd_empty;
  assign urun_p0 = run_p0 && slot_req && !cfg_flush_req && fifo_rd_empty;
  assign low_p0  = (state_p0 == ST_RUN) && (fifo_lvl < cfg_low_thr);

  assign fifo_rd_ena = pop_p0;
  assign fifo_flush  = (state_p0 == ST_FLUSH) && !rst;
  assign stat_state  = state_p0;

  always_comb begin
    state_nxt = state_p0;
    if (cfg_flush_req) begin
      state_nxt = ST_FLUSH;
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (cfg_ena) state_nxt = ST_PREFILL;
        end
        ST_PREFILL: begin
          if (!cfg_ena)                        state_nxt = ST_IDLE;
          else if (fifo_lvl >= cfg_start_thr)  state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!cfg_ena)     state_nxt = ST_FLUSH;
          else if (urun_p0) state_nxt = ST_PREFILL;
        end
        ST_FLUSH: begin
          if (fifo_rd_empty) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_p0 <= ST_IDLE;
    else     state_p0 <= state_nxt;
  end

  // ---- stage p1: slot response, one cycle after the request ----
  logic          vld_p1;
  logic [DW-1:0] data_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= slot_req;
      data_p1 <= pop_p0 ? fifo_rd_data : '0;
    end
  end

  assign slot_valid = vld_p1;
  assign slot_data  = data_p1;

  // Sticky status: a set event in the same cycle as stat_clr keeps the bit set.
  logic urun_sticky_p1;
  logic low_sticky_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      urun_sticky_p1 <= 1'b0;
      low_sticky_p1  <= 1'b0;
    end else begin
      urun_sticky_p1 <= urun_p0 || (urun_sticky_p1 && !stat_clr);
      low_sticky_p1  <= low_p0  || (low_sticky_p1  && !stat_clr);
    end
  end

  assign stat_underrun = urun_sticky_p1;
  assign stat_low      = low_sticky_p1;

`ifdef MC97_TX_FLOW_STATS_EN
  logic [URUN_CNT_W-1:0] urun_cnt_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      urun_cnt_p1 <= '0;
    end else if (stat_clr) begin
      urun_cnt_p1 <= urun_p0 ? URUN_CNT_W'(1) : '0;
    end else if (urun_p0 && !(&urun_cnt_p1)) begin
      urun_cnt_p1 <= urun_cnt_p1 + URUN_CNT_W'(1);
    end
  end

  assign stat_urun_cnt = urun_cnt_p1;
`endif

endmodule

// File: tb/tb_mc97_tx_flow_ctl.sv
// Bench for mc97_tx_flow_ctl: directed vector table, corner-case sequences and randomized traffic
// against a queue-based FIFO and a rule-level reference model.
module tb_mc97_tx_flow_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_ena;
  logic [8:0]  cfg_start_thr;
  logic [8:0]  cfg_low_thr;
  logic        cfg_flush_req;
  logic        stat_clr;
  logic [15:0] fifo_rd_data;
  logic        fifo_rd_empty;
  logic [8:0]  fifo_lvl;
  logic        slot_req;
  wire         fifo_rd_ena;
  wire         fifo_flush;
  wire  [15:0] slot_data;
  wire         slot_valid;
  wire  [1:0]  stat_state;
  wire         stat_underrun;
  wire         stat_low;
`ifdef MC97_TX_FLOW_STATS_EN
  wire  [15:0] stat_urun_cnt;
`endif

  always #5 clk = ~clk;

  mc97_tx_flow_ctl #(.LVL_W(9), .DW(16)) dut (
    .clk(clk), .rst(rst), .cfg_ena(cfg_ena), .cfg_start_thr(cfg_start_thr),
    .cfg_low_thr(cfg_low_thr), .cfg_flush_req(cfg_flush_req), .stat_clr(stat_clr),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .fifo_lvl(fifo_lvl),
    .fifo_rd_ena(fifo_rd_ena), .fifo_flush(fifo_flush), .slot_req(slot_req),
    .slot_data(slot_data), .slot_valid(slot_valid), .stat_state(stat_state),
    .stat_underrun(stat_underrun), .stat_low(stat_low)
`ifdef MC97_TX_FLOW_STATS_EN
    , .stat_urun_cnt(stat_urun_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // Behavioural FIFO (first-word-fall-through) and reference model state.
  logic [15:0] q[$];
  int  m_state = 0;   // 0 IDLE, 1 PREFILL, 2 RUN, 3 FLUSH
  bit  m_valid = 0;
  logic [15:0] m_data = 0;
  bit  m_urun = 0;
  bit  m_low = 0;
`ifdef MC97_TX_FLOW_STATS_EN
  int  m_cnt = 0;
`endif
  bit  last_flush = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic update_view();
    fifo_lvl      = 9'(q.size());
    fifo_rd_empty = (q.size() == 0);
    fifo_rd_data  = (q.size() != 0) ? q[0] : 16'hDEAD;
  endtask

  task automatic cycle(input bit push, input logic [15:0] pd);
    bit run, e_pop, e_fl, urun, low_evt, dut_pop, dut_fl;
    int ns;
    logic [15:0] tmp;
    @(negedge clk);
    run   = !rst && (m_state == 2);
    e_pop = run && slot_req && !cfg_flush_req && !fifo_rd_empty;
    urun  = run && slot_req && !cfg_flush_req && fifo_rd_empty;
    e_fl  = !rst && (m_state == 3);
    check("fifo_rd_ena", 32'(fifo_rd_ena), 32'(e_pop));
    check("fifo_flush", 32'(fifo_flush), 32'(e_fl));
    dut_pop = fifo_rd_ena;
    dut_fl  = fifo_flush;
    last_flush = dut_fl;
    if (rst) begin
      m_state = 0; m_valid = 0; m_data = 0; m_urun = 0; m_low = 0;
`ifdef MC97_TX_FLOW_STATS_EN
      m_cnt = 0;
`endif
    end else begin
      ns = m_state;
      if (cfg_flush_req) ns = 3;
      else if (m_state == 0) ns = cfg_ena ? 1 : 0;
      else if (m_state == 1) ns = !cfg_ena ? 0 : (fifo_lvl >= cfg_start_thr) ? 2 : 1;
      else if (m_state == 2) ns = !cfg_ena ? 3 : urun ? 1 : 2;
      else ns = fifo_rd_empty ? 0 : 3;
      low_evt = (m_state == 2) && (fifo_lvl < cfg_low_thr);
      m_valid = slot_req;
      m_data  = e_pop ? fifo_rd_data : 16'h0;
`ifdef MC97_TX_FLOW_STATS_EN
      if (stat_clr) m_cnt = urun ? 1 : 0;
      else if (urun && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
      m_urun  = urun || (m_urun && !stat_clr);
      m_low   = low_evt || (m_low && !stat_clr);
      m_state = ns;
    end
    @(posedge clk);
    #1;
    if (dut_pop && q.size() > 0) tmp = q.pop_front();
    if (dut_fl && q.size() > 0) tmp = q.pop_front();
    if (push) q.push_back(pd);
    update_view();
    cyc++;
    check("stat_state", 32'(stat_state), 32'(m_state));
    check("slot_valid", 32'(slot_valid), 32'(m_valid));
    check("slot_data", 32'(slot_data), 32'(m_data));
    check("stat_underrun", 32'(stat_underrun), 32'(m_urun));
    check("stat_low", 32'(stat_low), 32'(m_low));
`ifdef MC97_TX_FLOW_STATS_EN
    check("stat_urun_cnt", 32'(stat_urun_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic idle_inputs();
    cfg_ena = 0; cfg_flush_req = 0; stat_clr = 0; slot_req = 0;
    cfg_start_thr = 9'd0; cfg_low_thr = 9'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    q.delete();
    update_view();
    rst = 1;
    cycle(0, 16'h0);
    rst = 0;
  endtask

  task automatic wait_state(input string nm, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(stat_state) == target) break;
      cycle(0, 16'h0);
    end
    check(nm, 32'(stat_state), 32'(target));
  endtask

  typedef struct {
    bit rst, ena, req, clr, push;
    logic [15:0] pd;
    logic [1:0]  e_state;
    bit          e_valid;
    logic [15:0] e_data;
    bit          e_urun;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #7200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    bit push;
    int push_pct;
    int drain;
    logic [8:0] lvl_before;

    //            rst ena req clr push pd     st valid data urun
    tbl[0]  = '{1, 0, 0, 0, 0, 16'h0, 2'd0, 0, 16'h0, 0};
    tbl[1]  = '{0, 1, 0, 0, 1, 16'h0, 2'd1, 0, 16'h0, 0};
    tbl[2]  = '{0, 1, 0, 0, 1, 16'h1, 2'd1, 0, 16'h0, 0};
    tbl[3]  = '{0, 1, 0, 0, 1, 16'h2, 2'd1, 0, 16'h0, 0};
    tbl[4]  = '{0, 1, 0, 0, 1, 16'h3, 2'd1, 0, 16'h0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 16'h0, 2'd2, 0, 16'h0, 0};
    tbl[6]  = '{0, 1, 1, 0, 0, 16'h0, 2'd2, 1, 16'h0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0, 16'h0, 2'd2, 1, 16'h1, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 16'h0, 2'd2, 1, 16'h2, 0};
    tbl[9]  = '{0, 1, 1, 0, 0, 16'h0, 2'd2, 1, 16'h3, 0};
    tbl[10] = '{0, 1, 0, 0, 0, 16'h0, 2'd2, 0, 16'h0, 0};
    tbl[11] = '{0, 1, 1, 0, 0, 16'h0, 2'd1, 1, 16'h0, 1};
    tbl[12] = '{0, 1, 0, 1, 0, 16'h0, 2'd1, 0, 16'h0, 0};

    rst = 1;
    idle_inputs();
    update_view();
    #2;

    // Prefill to 4 words, play them back, then underrun and clear.
    cfg_start_thr = 9'd4;
    for (int i = 0; i < 13; i++) begin
      rst      = tbl[i].rst;
      cfg_ena  = tbl[i].ena;
      slot_req = tbl[i].req;
      stat_clr = tbl[i].clr;
      cycle(tbl[i].push, tbl[i].pd);
      check("tbl_state", 32'(stat_state), 32'(tbl[i].e_state));
      check("tbl_valid", 32'(slot_valid), 32'(tbl[i].e_valid));
      check("tbl_data", 32'(slot_data), 32'(tbl[i].e_data));
      check("tbl_urun", 32'(stat_underrun), 32'(tbl[i].e_urun));
    end
    rst = 0; slot_req = 0; stat_clr = 0;

    // Back-to-back requests with three words buffered.
    do_reset();
    cfg_start_thr = 9'd3; cfg_ena = 1;
    cycle(1, 16'hA0); cycle(1, 16'hA1); cycle(1, 16'hA2);
    wait_state("b2b_run", 2, 10);
    slot_req = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 16'h0);
      check("b2b_data", 32'(slot_data), 32'(16'hA0 + 16'(i)));
    end
    cycle(0, 16'h0);
    check("b2b_urun_data", 32'(slot_data), 32'h0);
    check("b2b_urun_state", 32'(stat_state), 32'd1);
    check("b2b_urun_flag", 32'(stat_underrun), 32'd1);
    slot_req = 0;

    // Flush of 10 buffered words with interleaved slot requests.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 16'h100 + 16'(i));
    cfg_flush_req = 1; slot_req = 1;
    cycle(0, 16'h0);
    cfg_flush_req = 0;
    check("flush_enter", 32'(stat_state), 32'd3);
    check("flush_req_data", 32'(slot_data), 32'h0);
    drain = 0;
    for (int i = 0; i < 40; i++) begin
      if (stat_state == 2'd0) break;
      slot_req = i[0];
      lvl_before = fifo_lvl;
      cycle(0, 16'h0);
      if (last_flush && lvl_before != 0) drain++;
    end
    slot_req = 0;
    check("flush_drain_cycles", 32'(drain), 32'd10);
    check("flush_to_idle", 32'(stat_state), 32'd0);

    // Low watermark while the level falls from 9 to 7.
    do_reset();
    cfg_start_thr = 9'd9; cfg_low_thr = 9'd8; cfg_ena = 1;
    for (int i = 0; i < 9; i++) cycle(1, 16'h200 + 16'(i));
    wait_state("low_run", 2, 10);
    slot_req = 1;
    cycle(0, 16'h0);
    cycle(0, 16'h0);
    slot_req = 0;
    check("low_before", 32'(stat_low), 32'd0);
    cycle(0, 16'h0);
    check("low_rise", 32'(stat_low), 32'd1);

    // Zero start threshold passes PREFILL on an empty FIFO; set wins over clear.
    do_reset();
    cfg_ena = 1;
    cycle(0, 16'h0); cycle(0, 16'h0);
    check("prefill_passthru", 32'(stat_state), 32'd2);
    slot_req = 1; stat_clr = 1;
    cycle(0, 16'h0);
    slot_req = 0; stat_clr = 0;
    check("set_over_clr", 32'(stat_underrun), 32'd1);

    // Reset while flushing, with status already set.
    do_reset();
    cfg_ena = 1;
    cycle(0, 16'h0); cycle(0, 16'h0);
    slot_req = 1;
    cycle(1, 16'h300);
    slot_req = 0;
    cycle(1, 16'h301); cycle(1, 16'h302);
    cfg_flush_req = 1;
    cycle(0, 16'h0);
    cfg_flush_req = 0;
    cycle(0, 16'h0);
    check("rstf_in_flush", 32'(stat_state), 32'd3);
    rst = 1; slot_req = 1;
    cycle(0, 16'h0);
    rst = 0; slot_req = 0;
    check("rstf_state", 32'(stat_state), 32'd0);
    check("rstf_valid", 32'(slot_valid), 32'd0);
    check("rstf_urun", 32'(stat_underrun), 32'd0);
    check("rstf_low", 32'(stat_low), 32'd0);
    cfg_ena = 0;
    cycle(0, 16'h0);
    check("rstf_flush_off", 32'(last_flush), 32'd0);

    // Randomized traffic.
    do_reset();
    cfg_ena = 1; cfg_start_thr = 9'd4; cfg_low_thr = 9'd3;
    push_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) push_pct = $urandom_range(10, 70);
      rst = ($urandom_range(0, 99) == 0);
      if (cfg_ena) begin
        if ($urandom_range(0, 99) == 0) cfg_ena = 0;
      end else begin
        if ($urandom_range(0, 9) == 0) cfg_ena = 1;
      end
      cfg_flush_req = ($urandom_range(0, 39) == 0);
      stat_clr      = ($urandom_range(0, 15) == 0);
      slot_req      = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) begin
        cfg_start_thr = 9'($urandom_range(0, 12));
        cfg_low_thr   = 9'($urandom_range(0, 12));
      end
      push = (q.size() < 500) && ($urandom_range(0, 99) < push_pct);
      cycle(push, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mc97_tx_flow_ctl.md
MC97_TX_FLOW_CTL -- requirements
Module: mc97_tx_flow_ctl

Interface
REQ-001 Parameter LVL_W, default 9, SHALL set the width of the FIFO level and both thresholds.
REQ-002 Parameter DW, default 16, SHALL set the sample width.
REQ-003 Port clk  in  1  SHALL be the clock; all logic is rising-edge.
REQ-004 Port rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 Port cfg_ena  in  1  SHALL enable playback (level).
REQ-006 Port cfg_start_thr  in  LVL_W  SHALL be the prefill level required to start or restart playback.
REQ-007 Port cfg_low_thr  in  LVL_W  SHALL be the low-watermark level.
REQ-008 Port cfg_flush_req  in  1  SHALL request a FIFO flush (pulse).
REQ-009 Port stat_clr  in  1  SHALL clear the sticky status bits and the counter (pulse).
REQ-010 Port fifo_rd_data  in  DW  SHALL carry the FIFO head word, valid while fifo_rd_empty=0 (first-word-fall-through).
REQ-011 Port fifo_rd_empty  in  1  SHALL be the FIFO empty flag.
REQ-012 Port fifo_lvl  in  LVL_W  SHALL be the current FIFO occupancy.
REQ-013 Port fifo_rd_ena  out  1  SHALL pop one word.
REQ-014 Port fifo_flush  out  1  SHALL drive the FIFO flush input.
REQ-015 Port slot_req  in  1  SHALL be the codec request for one sample (pulse, any spacing ≥1 cycle).
REQ-016 Port slot_data  out  DW  SHALL be the sample answering slot_req.
REQ-017 Port slot_valid  out  1  SHALL qualify slot_data (one-cycle pulse).
REQ-018 Port stat_state  out  2  SHALL be the current FSM state code.
REQ-019 Port stat_underrun  out  1  SHALL be the sticky underrun flag.
REQ-020 Port stat_low  out  1  SHALL be set when fifo_lvl < cfg_low_thr while in RUN (registered).

Function
REQ-021 FSM states SHALL be IDLE=0, PREFILL=1, RUN=2, FLUSH=3.
REQ-022 IDLE→PREFILL SHALL occur when cfg_ena=1.
REQ-023 PREFILL→RUN SHALL occur when fifo_lvl ≥ cfg_start_thr (unsigned compare); PREFILL→IDLE when cfg_ena=0.
REQ-024 RUN→FLUSH SHALL occur when cfg_ena=0; RUN→PREFILL on underrun.
REQ-025 cfg_flush_req SHALL force FLUSH from any state, with priority over every other transition.
REQ-026 In FLUSH, fifo_flush SHALL be 1; FLUSH→IDLE on the first cycle fifo_rd_empty=1.
REQ-027 fifo_flush SHALL be 0 in all other states; fifo_rd_ena SHALL be driven only in RUN.
REQ-028 Every slot_req SHALL produce exactly one slot_valid pulse, 1 cycle later, in every state.
REQ-029 In RUN with slot_req=1 and fifo_rd_empty=0, fifo_rd_ena SHALL be 1 in the same cycle, and slot_data SHALL register fifo_rd_data.
REQ-030 In RUN with slot_req=1 and fifo_rd_empty=1 (underrun), slot_data SHALL be 0, stat_underrun SHALL be set, and the state SHALL go to PREFILL.
REQ-031 In IDLE, PREFILL or FLUSH, or when slot_req coincides with cfg_flush_req, slot_data SHALL be 0 and no pop SHALL be issued.
REQ-032 stat_clr SHALL clear the sticky bits next cycle; a simultaneous set event SHALL win over stat_clr.
REQ-033 cfg_start_thr=0 SHALL make PREFILL pass through in 1 cycle, even when the FIFO is empty.

Reset
REQ-034 rst SHALL set: state IDLE, fifo_rd_ena=0, fifo_flush=0, slot_valid=0, slot_data=0, stat_underrun=0, stat_low=0, and the counter to 0.
REQ-035 rst asserted mid-RUN or mid-FLUSH SHALL abort the operation with no further pops or flush cycles, and any pending slot_valid SHALL be dropped.

Configuration
REQ-036 With MC97_TX_FLOW_STATS_EN defined, output stat_urun_cnt (16 bits) SHALL count underruns, saturate at 0xFFFF, and clear on stat_clr.
REQ-037 Without MC97_TX_FLOW_STATS_EN, the port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-038 The state encodings and the default DW/LVL_W constants SHALL live in shared package mc97_pkg.
REQ-039 The block SHALL be a single module with no sub-modules; the saturating counter SHALL be inline.

Verification
REQ-040 Scenario: cfg_start_thr=4, cfg_ena=1, FIFO filled 0..3 → RUN on the cycle fifo_lvl=4; four slot_req → slot_data 0,1,2,3.
REQ-041 Scenario: in RUN, FIFO drained, then slot_req → slot_data=0, stat_underrun=1, state=PREFILL, stat_urun_cnt=1.
REQ-042 Scenario: cfg_flush_req with fifo_lvl=10 → fifo_flush high until empty (10 cycles), then IDLE; concurrent slot_req answered with 0.
REQ-043 Scenario: cfg_low_thr=8, RUN with fifo_lvl 9→7 → stat_low rises 1 cycle after fifo_lvl=7.
REQ-044 Scenario: slot_req every cycle in RUN with 3 words buffered → three pops, the 4th request underruns.
REQ-045 Scenario: rst asserted in FLUSH → next cycle IDLE, fifo_flush=0, all status bits 0.
